// File: rtl/operand_entry_pkg.sv
// rtl/operand_entry_pkg.sv - shared types, limits and saturating edit arithmetic
package operand_entry_pkg;

    typedef enum logic [1:0] {
        ED_A   = 2'd0,
        ED_B   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_INC  = 2'd1,
        OP_DEC  = 2'd2,
        OP_NEG  = 2'd3
    } edit_e;

    localparam logic signed [3:0] S_MAX       = 4'sd7;
    localparam logic signed [3:0] S_MIN       = 4'sb1000;   // -8
    localparam logic        [3:0] U_MAX       = 4'd15;
    localparam logic        [1:0] MODE_SIGNED = 2'b11;

    // One edit step on a 4-bit operand, clamped to the range of the active number mode.
    function automatic logic [3:0] apply_edit(input logic [3:0] v, input edit_e op,
                                              input logic is_signed);
        logic [3:0] r;
        r = v;
        case (op)
            OP_INC: begin
                if (is_signed) r = ($signed(v) == S_MAX) ? v : v + 4'd1;
                else           r = (v == U_MAX)          ? v : v + 4'd1;
            end
            OP_DEC: begin
                if (is_signed) r = ($signed(v) == S_MIN) ? v : v - 4'd1;
                else           r = (v == 4'd0)           ? v : v - 4'd1;
            end
            OP_NEG: begin
                // -(-8) does not fit, so it clamps to +7; zero negates to itself.
                if (is_signed) r = ($signed(v) == S_MIN) ? S_MAX : 4'd0 - v;
            end
            default: r = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/operand_entry_if.sv
// rtl/operand_entry_if.sv - key/mode inputs and operand/status outputs of operand_entry
interface operand_entry_if;
    logic       KEY_NEXT;
    logic       KEY_INC;
    logic       KEY_DEC;
    logic       KEY_NEG;
    logic [1:0] SW_MODE;
    logic [3:0] OPA;
    logic [3:0] OPB;
    logic       EDIT_A;
    logic       EDIT_B;
    logic       DONE;
    logic       VALID;

    modport master (
        output KEY_NEXT, KEY_INC, KEY_DEC, KEY_NEG, SW_MODE,
        input  OPA, OPB, EDIT_A, EDIT_B, DONE, VALID
    );

    modport slave (
        input  KEY_NEXT, KEY_INC, KEY_DEC, KEY_NEG, SW_MODE,
        output OPA, OPB, EDIT_A, EDIT_B, DONE, VALID
    );
endinterface

// File: rtl/operand_entry_key_debounce.sv
// rtl/operand_entry_key_debounce.sv - active-low key synchronizer, debouncer and press pulse
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    // Two-flop synchronizer; idles released (high).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b1;
        end else if (sync2 == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= sync2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // One-cycle pulse on the accepted high-to-low edge only.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_d <= 1'b1;
            press    <= 1'b0;
        end else begin
            stable_d <= stable;
            press    <= stable_d & ~stable;
        end
    end
endmodule

// File: rtl/operand_entry.sv
// rtl/operand_entry.sv - pushbutton entry of two 4-bit comparator operands
module operand_entry #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic           CLK,
    input  logic           RST,
    operand_entry_if.slave bus
);
    import operand_entry_pkg::*;

    logic       press_next;
    logic       press_inc;
    logic       press_dec;
    logic       press_neg;
    logic [1:0] mode_s1;
    logic [1:0] mode_s2;
    logic       signed_q;
    logic       signed_now;
    logic       mode_change;
    edit_e      op;
    state_e     state;
    state_e     state_n;
    logic [3:0] opa;
    logic [3:0] opb;
    logic [3:0] opa_n;
    logic [3:0] opb_n;
    logic       edit_a;
    logic       edit_b;
    logic       done;
    logic       valid;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk(CLK), .rst(RST), .key(bus.KEY_NEXT), .press(press_next));
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clk(CLK), .rst(RST), .key(bus.KEY_INC), .press(press_inc));
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
        .clk(CLK), .rst(RST), .key(bus.KEY_DEC), .press(press_dec));
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_neg (
        .clk(CLK), .rst(RST), .key(bus.KEY_NEG), .press(press_neg));

    // Mode switch synchronizer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_s1 <= 2'b00;
            mode_s2 <= 2'b00;
        end else begin
            mode_s1 <= bus.SW_MODE;
            mode_s2 <= mode_s1;
        end
    end

    assign signed_now  = (mode_s2 == MODE_SIGNED);
    assign mode_change = (signed_now != signed_q);

    // Pick the single edit that acts this cycle: NEG beats INC beats DEC.
    always_comb begin
        op = OP_NONE;
        if (press_neg)      op = OP_NEG;
        else if (press_inc) op = OP_INC;
        else if (press_dec) op = OP_DEC;
    end

    // Next state and operands; a mode flip overrides everything, NEXT overrides edits.
    always_comb begin
        state_n = state;
        opa_n   = opa;
        opb_n   = opb;
        if (mode_change) begin
            state_n = ED_A;
            opa_n   = 4'd0;
            opb_n   = 4'd0;
        end else if (press_next) begin
            case (state)
                ED_A:    state_n = ED_B;
                ED_B:    state_n = COMMIT;
                default: state_n = ED_A;
            endcase
        end else if (state == ED_A) begin
            opa_n = apply_edit(opa, op, signed_q);
        end else if (state == ED_B) begin
            opb_n = apply_edit(opb, op, signed_q);
        end
    end

    // Entry FSM with registered operands and one-hot status outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ED_A;
            opa      <= 4'd0;
            opb      <= 4'd0;
            signed_q <= 1'b0;
            edit_a   <= 1'b1;
            edit_b   <= 1'b0;
            done     <= 1'b0;
            valid    <= 1'b0;
        end else begin
            state    <= state_n;
            opa      <= opa_n;
            opb      <= opb_n;
            signed_q <= signed_now;
            edit_a   <= (state_n == ED_A);
            edit_b   <= (state_n == ED_B);
            done     <= (state_n == COMMIT);
            valid    <= (state_n == COMMIT) && (state != COMMIT);
        end
    end

    assign bus.OPA    = opa;
    assign bus.OPB    = opb;
    assign bus.EDIT_A = edit_a;
    assign bus.EDIT_B = edit_b;
    assign bus.DONE   = done;
    assign bus.VALID  = valid;
endmodule
